// File: rtl/status_cond_unit_if.sv
// Status/condition bundle between the pipeline and status_cond_unit.
// master: pipeline side driving EXE/ID info; slave: the status/condition unit.
interface status_cond_unit_if;
   logic [3:0] statusBits;
   logic       sUpdate;
   logic       freeze;
   logic       saveReq;
   logic       restoreReq;
   logic [3:0] condCode;
   logic       condValid;
   logic       condPass;
   logic       condUndef;
   logic       flagStall;
   logic [3:0] statusReg;
   logic       carryIn;
   logic [3:0] shadowReg;

   modport master (
      output statusBits, sUpdate, freeze, saveReq, restoreReq, condCode, condValid,
      input  condPass, condUndef, flagStall, statusReg, carryIn, shadowReg
   );

   modport slave (
      input  statusBits, sUpdate, freeze, saveReq, restoreReq, condCode, condValid,
      output condPass, condUndef, flagStall, statusReg, carryIn, shadowReg
   );
endinterface

// File: rtl/status_cond_unit.sv
// NZCV status register with shadow copy, ARM condition decode and EXE->ID flag hazard handling.
// Macro STATUS_COND_FWD_EN: forward pending flags to the decode instead of stalling.
module status_cond_unit (
   input logic               clk,
   input logic               rst,
   status_cond_unit_if.slave bus
);
   logic [3:0]  status_reg;
   logic [3:0]  shadow_reg;
   logic [3:0]  pend_nzcv;
   logic [3:0]  eval_flags;
   logic [15:0] cond_vec;

   // Flags are packed {N,Z,V,C}; code 1111 (NV) never passes.
   function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
      logic n, z, v, c;
      n = f[3];
      z = f[2];
      v = f[1];
      c = f[0];
      case (code)
         4'h0:    cond_eval = z;
         4'h1:    cond_eval = !z;
         4'h2:    cond_eval = c;
         4'h3:    cond_eval = !c;
         4'h4:    cond_eval = n;
         4'h5:    cond_eval = !n;
         4'h6:    cond_eval = v;
         4'h7:    cond_eval = !v;
         4'h8:    cond_eval = c & !z;
         4'h9:    cond_eval = !c | z;
         4'hA:    cond_eval = (n == v);
         4'hB:    cond_eval = (n != v);
         4'hC:    cond_eval = !z & (n == v);
         4'hD:    cond_eval = z | (n != v);
         4'hE:    cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   // Restore outranks a fresh ALU update.
   assign pend_nzcv = bus.restoreReq ? shadow_reg :
                      (bus.sUpdate ? bus.statusBits : status_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         status_reg <= 4'b0000;
         shadow_reg <= 4'b0000;
      end else if (!bus.freeze) begin
         status_reg <= pend_nzcv;
         if (bus.saveReq) begin
            shadow_reg <= status_reg;
         end
      end
   end

`ifdef STATUS_COND_FWD_EN
   assign eval_flags    = pend_nzcv;
   assign bus.flagStall = 1'b0;
`else
   logic flag_dep;
   logic hazard;

   assign eval_flags    = status_reg;
   assign flag_dep      = (bus.condCode[3:1] != 3'b111);
   // Independent of freeze: a frozen EXE still has its flags outstanding.
   assign hazard        = bus.condValid & flag_dep & (bus.sUpdate | bus.restoreReq);
   assign bus.flagStall = hazard;
`endif

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_cond
         assign cond_vec[gi] = cond_eval(4'(gi), eval_flags);
      end
   endgenerate

   assign bus.condPass  = bus.condValid & cond_vec[bus.condCode];
   assign bus.condUndef = bus.condValid & (bus.condCode == 4'b1111);
   assign bus.statusReg = status_reg;
   assign bus.carryIn   = status_reg[0];
   assign bus.shadowReg = shadow_reg;
endmodule
